hdmi_period_detect: RTL and testbench
=====================================

Name: hdmi_period_detect

Overview:
- Sits between the TMDS symbol decoder and hdmi_stream, in the hdmi_clk domain.
- Classifies each aligned 10-bit TMDS character triple as control, preamble, guard band, video data or data island (TERC4).
- Outputs a registered video data-enable, data-island nibbles and clean hsync/vsync, so hdmi_stream stops counting island/guard characters as pixels.

Parameters:
- PREAMBLE_LEN, 8, consecutive identical preamble characters required before a guard band.
- GUARD_LEN, 2, guard band characters (leading video, leading and trailing island).
- MAX_ISLAND, 576, island characters (18 packets × 32) before forced abort.

Ports:
- hdmi_clk  input  1  pixel clock.
- reset_n  input  1  asynchronous, active-low reset.
- valid  input  1  decoder symbol lock; characters ignored when low.
- sym0, sym1, sym2  input  10 each  raw aligned TMDS characters, channels 0/1/2.
- d0, d1, d2  input  8 each  TMDS-decoded video bytes for the same characters.
- video_de  output  1  registered; r/g/b hold an active pixel.
- r, g, b  output  8 each  registered d2/d1/d0.
- island_de  output  1  registered; island_data valid.
- island_data  output  12  TERC4 nibbles {ch2, ch1, ch0}.
- sync  output  2  {vsync, hsync}, registered, held between updates.
- period_err  output  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset values: all outputs 0; state CTRL; counters 0.
- Latency: every output is one register after its input character.
- Control tokens (CTL = {b1, b0}):
  - 00 = 1101010100
  - 01 = 0010101011
  - 10 = 0101010100
  - 11 = 1010101011
- Video guard: ch0/ch2 = 1011001100, ch1 = 0100110011.
- Island guard: ch1/ch2 = 0100110011; ch0 = TERC4 of {1, 1, vsync, hsync}.
- TERC4 decode table per HDMI 1.4; non-TERC4 character flagged invalid.
- Preamble: ch0 is any control token; {ch2 CTL, ch1 CTL} = 0001 means video, 0101 means island.
- Whenever ch0 carries a control token: sync ← its two bits.
- States and transitions:
  - CTRL: when preamble code is seen, load counter = 1 → PRE.
  - PRE: same code increments the counter.
    - A differing control pattern restarts the count.
    - Counter ≥ PREAMBLE_LEN and the matching guard is seen → GUARD (count 1).
    - Guard seen before PREAMBLE_LEN, or non-control data → period_err, then CTRL.
  - GUARD: needs GUARD_LEN consecutive guard characters, then enters VIDEO or ISLAND.
    - Mismatch → period_err, then CTRL.
  - VIDEO: video_de = 1 per character.
    - Any control token on ch0 → CTRL with video_de = 0 for that character; no trailing guard is expected.
  - ISLAND: island_de = 1; island_data gets TERC4 nibbles; sync ← ch0 nibble bits[1:0].
    - Island guard → TRAIL.
    - Invalid TERC4 → period_err, then CTRL.
    - Count reaching MAX_ISLAND → period_err, then CTRL.
  - TRAIL: GUARD_LEN island guards → CTRL.
    - A fresh video or island preamble (one pattern) goes directly to PRE.
    - Any other character → period_err, then CTRL.
- valid low: next state CTRL, counters cleared, video_de/island_de = 0 that cycle, sync held.
- reset_n low mid-frame: immediate return to reset values; the first legal preamble resynchronises.
- Counters saturate; none wrap.

Optional Feature:
- Macro HDMI_DVI_FALLBACK_EN.
- With it: a DVI latch is set after one full vsync period (rising vsync to rising vsync) with no valid preamble.
  - While the latch is set, CTRL → VIDEO on any non-control character; VIDEO → CTRL on a control token.
  - The latch clears on any valid preamble.
- Without it: video requires preamble plus guard; DVI sources produce no video_de.

Decomposition:
- Package hdmi_pkg holds:
  - the control-token and guard-band constants;
  - the TERC4 symbol table;
  - the state enum (CTRL, PRE, GUARD, VIDEO, ISLAND, TRAIL);
  - the preamble code constants.
- One sub-module, terc4_decode: combinational 10→4 bit decode plus a valid flag. Instantiated three times.

Test Plan:
- 8× preamble 0001, 2× video guard, then 640 data characters with d2/d1/d0 = 0x11/0x22/0x33, then control token 00:
  - exactly 640 video_de cycles, each one cycle after its input, with r/g/b = 0x11/0x22/0x33;
  - video_de = 0 on guard characters.
- 8× preamble 0101, 2× island guard, 32 TERC4 characters with nibbles 0x5 on all channels, 2× trailing guard:
  - island_de high for 32 cycles, island_data = 0x555;
  - ends in CTRL with no period_err.
- 5× preamble 0001 then guard → one period_err pulse, no video_de; a following full legal sequence then yields video.
- Video period with valid dropped for 3 cycles → video_de = 0 during the dropout and state returns to CTRL; video resumes only after a new preamble.
- Control tokens 10 then 11 on ch0 → sync becomes 2'b10 then 2'b11 one cycle later each; sync is held through the following video.
- HDMI_DVI_FALLBACK_EN with two vsync pulses and no preambles → after the second vsync, data characters assert video_de; the feature-off build never asserts it.

Source files
------------

// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - TMDS constants, TERC4 table and types for the HDMI period detector
//
// Purpose: shared definitions for hdmi_period_detect and terc4_decode.
//   - control tokens, video/island guard-band characters, preamble codes
//   - TERC4 symbol table (nibble -> 10-bit character)
//   - period state enum, control-token decode and saturating counter helpers
// Ports: none (package).
package hdmi_pkg;

  localparam int CNT_W = 10;

  // Control tokens, indexed by CTL = {b1, b0}
  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;

  // Guard bands; island ch0 guard is TERC4 {1, 1, vsync, hsync}
  localparam logic [9:0] VGUARD_CH0  = 10'b1011001100;
  localparam logic [9:0] VGUARD_CH1  = 10'b0100110011;
  localparam logic [9:0] VGUARD_CH2  = 10'b1011001100;
  localparam logic [9:0] IGUARD_CH12 = 10'b0100110011;

  // Preamble codes {ch2 CTL, ch1 CTL}
  localparam logic [3:0] PRE_VIDEO  = 4'b0001;
  localparam logic [3:0] PRE_ISLAND = 4'b0101;

  typedef enum logic [2:0] {
    CTRL,
    PRE,
    GUARD,
    VIDEO,
    ISLAND,
    TRAIL
  } state_e;

  typedef struct packed {
    logic       ok;
    logic [1:0] bits;
  } ctl_t;

  function automatic ctl_t ctl_decode(input logic [9:0] s);
    ctl_t c;
    c.ok   = 1'b1;
    c.bits = 2'b00;
    case (s)
      CTL_00:  c.bits = 2'b00;
      CTL_01:  c.bits = 2'b01;
      CTL_10:  c.bits = 2'b10;
      CTL_11:  c.bits = 2'b11;
      default: c.ok = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic [9:0] terc4_symbol(input logic [3:0] n);
    logic [9:0] s;
    case (n)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/terc4_decode.sv
// rtl/terc4_decode.sv - combinational TERC4 character to nibble decoder
//
// Purpose: maps a 10-bit TMDS character back to its TERC4 nibble.
// Ports:
//   sym_i    in  10  raw TMDS character
//   nibble_o out  4  decoded nibble (0 when invalid)
//   valid_o  out  1  character is one of the 16 TERC4 symbols
module terc4_decode
  import hdmi_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic [3:0] nibble_o,
  output logic       valid_o
);

  always_comb begin
    nibble_o = 4'h0;
    valid_o  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sym_i == terc4_symbol(4'(i))) begin
        nibble_o = 4'(i);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdmi_period_detect.sv
// rtl/hdmi_period_detect.sv - classifies TMDS character triples into HDMI periods
//
// Purpose: tracks control / preamble / guard / video / data-island periods and
// emits a registered video data-enable, island nibbles and clean sync.
// Optional macro HDMI_DVI_FALLBACK_EN: after a full vsync period with no
// preamble, plain data characters are treated as video (DVI source).
// Ports:
//   hdmi_clk, reset_n          in   pixel clock, async active-low reset
//   valid                      in   decoder lock; characters ignored when low
//   sym0/1/2                   in   raw TMDS characters, channels 0/1/2
//   d0/1/2                     in   decoded video bytes for the same characters
//   video_de, r, g, b          out  active pixel flag and pixel (d2/d1/d0)
//   island_de, island_data     out  TERC4 nibbles {ch2, ch1, ch0}
//   sync                       out  {vsync, hsync}, held between updates
//   period_err                 out  one-cycle protocol violation pulse
module hdmi_period_detect
  import hdmi_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int MAX_ISLAND   = 576
) (
  input  logic        hdmi_clk,
  input  logic        reset_n,
  input  logic        valid,
  input  logic [9:0]  sym0,
  input  logic [9:0]  sym1,
  input  logic [9:0]  sym2,
  input  logic [7:0]  d0,
  input  logic [7:0]  d1,
  input  logic [7:0]  d2,
  output logic        video_de,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        island_de,
  output logic [11:0] island_data,
  output logic [1:0]  sync,
  output logic        period_err
);

  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LEN_C = CNT_W'(PREAMBLE_LEN);
  localparam logic [CNT_W-1:0] GRD_LEN_C = CNT_W'(GUARD_LEN);
  localparam logic [CNT_W-1:0] MAX_ISL_C = CNT_W'(MAX_ISLAND);

  // Character classification
  ctl_t       c0, c1, c2;
  logic [3:0] t0_nib, t1_nib, t2_nib;
  logic       t0_ok, t1_ok, t2_ok;

  assign c0 = ctl_decode(sym0);
  assign c1 = ctl_decode(sym1);
  assign c2 = ctl_decode(sym2);

  terc4_decode u_terc4_ch0 (.sym_i(sym0), .nibble_o(t0_nib), .valid_o(t0_ok));
  terc4_decode u_terc4_ch1 (.sym_i(sym1), .nibble_o(t1_nib), .valid_o(t1_ok));
  terc4_decode u_terc4_ch2 (.sym_i(sym2), .nibble_o(t2_nib), .valid_o(t2_ok));

  logic all_ctl, pre_vid, pre_isl, vid_guard, isl_guard, terc4_ok;

  assign all_ctl   = c0.ok & c1.ok & c2.ok;
  assign pre_vid   = all_ctl & ({c2.bits, c1.bits} == PRE_VIDEO);
  assign pre_isl   = all_ctl & ({c2.bits, c1.bits} == PRE_ISLAND);
  assign vid_guard = (sym0 == VGUARD_CH0) & (sym1 == VGUARD_CH1) & (sym2 == VGUARD_CH2);
  assign isl_guard = (sym1 == IGUARD_CH12) & (sym2 == IGUARD_CH12) & t0_ok & (t0_nib[3:2] == 2'b11);
  assign terc4_ok  = t0_ok & t1_ok & t2_ok;

  // State
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              isl_q, isl_d;          // period kind announced by the preamble
  logic [1:0]        sync_q, sync_d;
  logic              vde_q, vde_d, ide_q, ide_d, err_q, err_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic [11:0]       idata_q, idata_d;
  logic              dvi_mode;

  state_e payload_st;
  logic   pre_same, guard_same;

  assign payload_st = isl_q ? ISLAND : VIDEO;
  assign pre_same   = isl_q ? pre_isl : pre_vid;
  assign guard_same = isl_q ? isl_guard : vid_guard;

  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CTRL;
      cnt_q   <= '0;
      isl_q   <= 1'b0;
      sync_q  <= 2'b00;
      vde_q   <= 1'b0;
      ide_q   <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= 8'h00;
      g_q     <= 8'h00;
      b_q     <= 8'h00;
      idata_q <= 12'h000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isl_q   <= isl_d;
      sync_q  <= sync_d;
      vde_q   <= vde_d;
      ide_q   <= ide_d;
      err_q   <= err_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      idata_q <= idata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isl_d   = isl_q;
    sync_d  = sync_q;
    vde_d   = 1'b0;
    ide_d   = 1'b0;
    err_d   = 1'b0;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    idata_d = idata_q;

    if (!valid) begin
      state_d = CTRL;
      cnt_d   = '0;
    end else begin
      if (c0.ok) sync_d = c0.bits;

      case (state_q)
        CTRL: begin
          if (pre_vid || pre_isl) begin
            state_d = PRE;
            cnt_d   = ONE_C;
            isl_d   = pre_isl;
          end else if (dvi_mode && !c0.ok) begin
            state_d = VIDEO;
            vde_d   = 1'b1;
          end
        end

        PRE: begin
          if (pre_same) begin
            cnt_d = sat_inc(cnt_q);
          end else if (pre_vid || pre_isl) begin
            // Switched preamble kind: count starts over for the new one
            cnt_d = ONE_C;
            isl_d = pre_isl;
          end else if (all_ctl) begin
            // Plain blanking control pattern abandons the preamble quietly
            state_d = CTRL;
            cnt_d   = '0;
          end else if (guard_same && cnt_q >= PRE_LEN_C) begin
            if (GRD_LEN_C > ONE_C) begin
              state_d = GUARD;
              cnt_d   = ONE_C;
            end else begin
              state_d = payload_st;
              cnt_d   = '0;
            end
          end else begin
            err_d = 1'b1;
          end
        end

        GUARD: begin
          if (guard_same) begin
            if (sat_inc(cnt_q) >= GRD_LEN_C) begin
              state_d = payload_st;
              cnt_d   = '0;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end else begin
            err_d = 1'b1;
          end
        end

        VIDEO: begin
          if (c0.ok) state_d = CTRL;
          else       vde_d   = 1'b1;
        end

        ISLAND: begin
          // Guard test first: island guard ch0 is itself a valid TERC4 symbol
          if (isl_guard) begin
            sync_d = t0_nib[1:0];
            if (GRD_LEN_C > ONE_C) begin
              state_d = TRAIL;
              cnt_d   = ONE_C;
            end else begin
              state_d = CTRL;
              cnt_d   = '0;
            end
          end else if (terc4_ok && cnt_q < MAX_ISL_C) begin
            ide_d   = 1'b1;
            idata_d = {t2_nib, t1_nib, t0_nib};
            sync_d  = t0_nib[1:0];
            cnt_d   = sat_inc(cnt_q);
          end else begin
            err_d = 1'b1;
          end
        end

        TRAIL: begin
          if (isl_guard) begin
            sync_d = t0_nib[1:0];
            if (sat_inc(cnt_q) >= GRD_LEN_C) begin
              state_d = CTRL;
              cnt_d   = '0;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end else if (pre_vid || pre_isl) begin
            state_d = PRE;
            cnt_d   = ONE_C;
            isl_d   = pre_isl;
          end else begin
            err_d = 1'b1;
          end
        end

        default: begin
          state_d = CTRL;
          cnt_d   = '0;
        end
      endcase

      if (vde_d) begin
        r_d = d2;
        g_d = d1;
        b_d = d0;
      end
      if (err_d) begin
        state_d = CTRL;
        cnt_d   = '0;
      end
    end
  end

`ifdef HDMI_DVI_FALLBACK_EN
  // arm_q: one rising vsync seen since the last preamble; a second one
  // completes a full vsync period without preambles and latches DVI mode.
  logic dvi_q, dvi_d, arm_q, arm_d;

  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      dvi_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      dvi_q <= dvi_d;
      arm_q <= arm_d;
    end
  end

  always_comb begin
    dvi_d = dvi_q;
    arm_d = arm_q;
    if (valid && (pre_vid || pre_isl)) begin
      dvi_d = 1'b0;
      arm_d = 1'b0;
    end else if (sync_d[1] && !sync_q[1]) begin
      dvi_d = dvi_q | arm_q;
      arm_d = 1'b1;
    end
  end

  assign dvi_mode = dvi_q;
`else
  assign dvi_mode = 1'b0;
`endif

  assign video_de    = vde_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign island_de   = ide_q;
  assign island_data = idata_q;
  assign sync        = sync_q;
  assign period_err  = err_q;

endmodule

// File: tb/tb_hdmi_period_detect.sv
// tb/tb_hdmi_period_detect.sv - directed self-checking bench for hdmi_period_detect
module tb_hdmi_period_detect;

  localparam logic [9:0] CTL00 = 10'b1101010100;
  localparam logic [9:0] CTL01 = 10'b0010101011;
  localparam logic [9:0] CTL10 = 10'b0101010100;
  localparam logic [9:0] CTL11 = 10'b1010101011;
  localparam logic [9:0] VG02  = 10'b1011001100;
  localparam logic [9:0] GD1   = 10'b0100110011;
  localparam logic [9:0] IG0   = 10'b1010001110;  // TERC4 0xC: island guard, vsync=0 hsync=0
  localparam logic [9:0] T4_5  = 10'b0100011110;  // TERC4 0x5
  localparam logic [9:0] DSYM  = 10'b0111110000;  // ordinary video character

`ifdef HDMI_DVI_FALLBACK_EN
  localparam int DVI_PIX = 3;
`else
  localparam int DVI_PIX = 0;
`endif

  logic        hdmi_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic        valid    = 1'b0;
  logic [9:0]  sym0 = CTL00, sym1 = CTL00, sym2 = CTL00;
  logic [7:0]  d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
  logic        video_de, island_de, period_err;
  logic [7:0]  r, g, b;
  logic [11:0] island_data;
  logic [1:0]  sync;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hdmi_clk = ~hdmi_clk;

  hdmi_period_detect dut (
    .hdmi_clk   (hdmi_clk),
    .reset_n    (reset_n),
    .valid      (valid),
    .sym0       (sym0),
    .sym1       (sym1),
    .sym2       (sym2),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .video_de   (video_de),
    .r          (r),
    .g          (g),
    .b          (b),
    .island_de  (island_de),
    .island_data(island_data),
    .sync       (sync),
    .period_err (period_err)
  );

  // One character per clock; returns 1 ns after the edge so outputs are settled
  task automatic put(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2,
                     input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    sym0 = s0; sym1 = s1; sym2 = s2;
    d0 = a0; d1 = a1; d2 = a2;
    @(posedge hdmi_clk);
    #1;
  endtask

  task automatic pre_vid(input int n);
    for (int i = 0; i < n; i++) put(CTL00, CTL01, CTL00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic pre_isl(input int n);
    for (int i = 0; i < n; i++) put(CTL00, CTL01, CTL01, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic vguard();
    put(VG02, GD1, VG02, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic iguard();
    put(IG0, GD1, GD1, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic pix(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    put(DSYM, DSYM, DSYM, bb, gg, rr);
  endtask

  task automatic ctl(input logic [9:0] t);
    put(t, CTL00, CTL00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    valid   = 1'b0;
    sym0 = CTL00; sym1 = CTL00; sym2 = CTL00;
    repeat (2) @(posedge hdmi_clk);
    #1;
    reset_n = 1'b1;
    valid   = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid   = 1'b1;
    pix(8'h11, 8'h22, 8'h33);
    n_tests++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL reset_video_de got %b want 0", video_de); end
    n_tests++; if (island_de !== 1'b0) begin n_fail++; $display("FAIL reset_island_de got %b want 0", island_de); end
    n_tests++; if (island_data !== 12'h000) begin n_fail++; $display("FAIL reset_island_data got %h want 000", island_data); end
    n_tests++; if (sync !== 2'b00) begin n_fail++; $display("FAIL reset_sync got %b want 00", sync); end
    n_tests++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL reset_period_err got %b want 0", period_err); end
    n_tests++; if ({r, g, b} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb got %h want 000000", {r, g, b}); end
    reset_n = 1'b1;
  endtask

  task automatic test_video();
    int good;
    int errs;
    apply_reset();
    errs = 0;
    for (int i = 0; i < 8; i++) begin pre_vid(1); if (video_de !== 1'b0 || period_err !== 1'b0) errs++; end
    vguard();
    n_tests++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL video_guard1_de got %b want 0", video_de); end
    vguard();
    n_tests++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL video_guard2_de got %b want 0", video_de); end
    good = 0;
    for (int i = 0; i < 640; i++) begin
      pix(8'h11, 8'h22, 8'h33);
      if (video_de === 1'b1 && r === 8'h11 && g === 8'h22 && b === 8'h33) good++;
      if (period_err !== 1'b0) errs++;
    end
    n_tests++; if (good !== 640) begin n_fail++; $display("FAIL video_pixels got %0d want 640", good); end
    ctl(CTL00);
    n_tests++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL video_end_de got %b want 0", video_de); end
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL video_no_err got %0d want 0", errs); end
  endtask

  task automatic test_island();
    int good;
    int errs;
    apply_reset();
    errs = 0;
    for (int i = 0; i < 8; i++) begin pre_isl(1); if (period_err !== 1'b0) errs++; end
    iguard();
    iguard();
    n_tests++; if (island_de !== 1'b0) begin n_fail++; $display("FAIL island_lead_guard_de got %b want 0", island_de); end
    good = 0;
    for (int i = 0; i < 32; i++) begin
      put(T4_5, T4_5, T4_5, 8'h00, 8'h00, 8'h00);
      if (island_de === 1'b1 && island_data === 12'h555) good++;
      if (period_err !== 1'b0 || video_de !== 1'b0) errs++;
    end
    n_tests++; if (good !== 32) begin n_fail++; $display("FAIL island_chars got %0d want 32", good); end
    n_tests++; if (sync !== 2'b01) begin n_fail++; $display("FAIL island_sync got %b want 01", sync); end
    iguard(); if (period_err !== 1'b0) errs++;
    iguard(); if (period_err !== 1'b0) errs++;
    n_tests++; if (island_de !== 1'b0) begin n_fail++; $display("FAIL island_trail_de got %b want 0", island_de); end
    // Plain control is only legal once back in CTRL
    ctl(CTL00); if (period_err !== 1'b0) errs++;
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL island_no_err got %0d want 0", errs); end
  endtask

  task automatic test_short_preamble();
    apply_reset();
    pre_vid(5);
    n_tests++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL short_pre_early_err got %b want 0", period_err); end
    vguard();
    n_tests++; if (period_err !== 1'b1) begin n_fail++; $display("FAIL short_pre_err got %b want 1", period_err); end
    n_tests++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL short_pre_de got %b want 0", video_de); end
    ctl(CTL00);
    n_tests++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL short_pre_pulse got %b want 0", period_err); end
    pre_vid(8);
    vguard();
    vguard();
    pix(8'hA5, 8'h5A, 8'hC3);
    n_tests++; if (video_de !== 1'b1 || {r, g, b} !== 24'hA55AC3) begin
      n_fail++; $display("FAIL short_pre_recover got de=%b rgb=%h want de=1 rgb=a55ac3", video_de, {r, g, b});
    end
  endtask

  task automatic test_dropout();
    int hits;
    apply_reset();
    pre_vid(8);
    vguard();
    vguard();
    pix(8'h01, 8'h02, 8'h03);
    pix(8'h01, 8'h02, 8'h03);
    n_tests++; if (video_de !== 1'b1) begin n_fail++; $display("FAIL dropout_pre_de got %b want 1", video_de); end
    valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 3; i++) begin pix(8'h04, 8'h05, 8'h06); if (video_de !== 1'b0) hits++; end
    n_tests++; if (hits !== 0) begin n_fail++; $display("FAIL dropout_de got %0d cycles want 0", hits); end
    n_tests++; if (r !== 8'h01) begin n_fail++; $display("FAIL dropout_r_hold got %h want 01", r); end
    valid = 1'b1;
    hits = 0;
    for (int i = 0; i < 3; i++) begin pix(8'h07, 8'h08, 8'h09); if (video_de !== 1'b0) hits++; end
    n_tests++; if (hits !== 0) begin n_fail++; $display("FAIL dropout_resume_de got %0d cycles want 0", hits); end
    pre_vid(8);
    vguard();
    vguard();
    pix(8'h0A, 8'h0B, 8'h0C);
    n_tests++; if (video_de !== 1'b1 || r !== 8'h0A) begin
      n_fail++; $display("FAIL dropout_relock got de=%b r=%h want de=1 r=0a", video_de, r);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    pre_vid(8);
    vguard();
    vguard();
    pix(8'h44, 8'h55, 8'h66);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++; if (video_de !== 1'b0 || r !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_async got de=%b r=%h want de=0 r=00", video_de, r);
    end
    @(posedge hdmi_clk);
    #1;
    reset_n = 1'b1;
    pix(8'h44, 8'h55, 8'h66);
    n_tests++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL mid_reset_nolock got %b want 0", video_de); end
    pre_vid(8);
    vguard();
    vguard();
    pix(8'h44, 8'h55, 8'h66);
    n_tests++; if (video_de !== 1'b1) begin n_fail++; $display("FAIL mid_reset_relock got %b want 1", video_de); end
  endtask

  task automatic test_sync();
    apply_reset();
    ctl(CTL10);
    n_tests++; if (sync !== 2'b10) begin n_fail++; $display("FAIL sync_10 got %b want 10", sync); end
    ctl(CTL11);
    n_tests++; if (sync !== 2'b11) begin n_fail++; $display("FAIL sync_11 got %b want 11", sync); end
    for (int i = 0; i < 8; i++) put(CTL11, CTL01, CTL00, 8'h00, 8'h00, 8'h00);
    vguard();
    vguard();
    for (int i = 0; i < 4; i++) pix(8'h77, 8'h88, 8'h99);
    n_tests++; if (sync !== 2'b11 || video_de !== 1'b1) begin
      n_fail++; $display("FAIL sync_hold got sync=%b de=%b want sync=11 de=1", sync, video_de);
    end
  endtask

  task automatic test_dvi();
    int hits;
    apply_reset();
    ctl(CTL00);
    ctl(CTL10);
    ctl(CTL10);
    ctl(CTL00);
    pix(8'h12, 8'h34, 8'h56);
    n_tests++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL dvi_one_vsync got %b want 0", video_de); end
    ctl(CTL00);
    ctl(CTL10);
    ctl(CTL00);
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      pix(8'h12, 8'h34, 8'h56);
      if (video_de === 1'b1 && r === 8'h12 && b === 8'h56) hits++;
    end
    n_tests++; if (hits !== DVI_PIX) begin n_fail++; $display("FAIL dvi_pixels got %0d want %0d", hits, DVI_PIX); end
    ctl(CTL00);
    n_tests++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL dvi_end_de got %b want 0", video_de); end
  endtask

  initial begin
    test_reset();
    test_video();
    test_island();
    test_short_preamble();
    test_dropout();
    test_mid_reset();
    test_sync();
    test_dvi();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
